// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: cache-side request/response and memory-side line port bundle.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [LINE_W-1:0] ic_rdata;
    logic              ic_ack;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic [LINE_W-1:0] dc_rdata;
    logic              dc_ack;
    logic              ram_en;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [LINE_W-1:0] ram_wdata;
    logic [LINE_W-1:0] ram_rdata;
    logic              ram_valid;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, ram_rdata, ram_valid,
        output ic_rdata, ic_ack, dc_rdata, dc_ack, ram_en, ram_write, ram_addr, ram_wdata
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, ram_rdata, ram_valid,
        input  ic_rdata, ic_ack, dc_rdata, dc_ack, ram_en, ram_write, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises I-cache refills and D-cache refills/write-backs onto one memory line port.
// Define ARB_PERF_CNT_EN to build the grant/busy performance counters; otherwise they read 0.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic [31:0]         perf_ic_cnt,
    output logic [31:0]         perf_dc_cnt,
    output logic [31:0]         perf_busy_cnt
);
    localparam int OFF = $clog2(LINE_W / 8);
    localparam int SW  = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [SW-1:0]     starve_cnt, starve_nx;
    logic              own_dc, we_q;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [LINE_W-1:0] wdata_q, ic_rdata_q, dc_rdata_q;
    logic              grant_ic, grant_dc;

    always_comb begin
        grant_ic  = state == IDLE && bus.ic_req && (!bus.dc_req || starve_cnt == SMAX);
        grant_dc  = state == IDLE && bus.dc_req && !grant_ic;
        sel_addr  = grant_dc ? bus.dc_addr : bus.ic_addr;
        state_nx  = state;
        unique case (state)
            IDLE:    state_nx = (grant_ic || grant_dc) ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = bus.ram_valid ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
        // the guard only counts D grants that actually made a waiting I-cache wait longer
        starve_nx = state != IDLE                   ? starve_cnt :
                    (grant_ic || !bus.ic_req)       ? '0 :
                    (grant_dc && starve_cnt != SMAX) ? starve_cnt + 1'b1 : starve_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            own_dc     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            if (grant_ic || grant_dc) begin
                own_dc  <= grant_dc;
                we_q    <= grant_dc && bus.dc_we;
                addr_q  <= {sel_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                wdata_q <= grant_dc ? bus.dc_wdata : '0;
            end
            if (state == WAIT && bus.ram_valid && !we_q) begin
                if (own_dc) dc_rdata_q <= bus.ram_rdata;
                else        ic_rdata_q <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_en    = state == ISSUE;
    assign bus.ram_write = state == ISSUE && we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ic_ack    = state == RESP && !own_dc;
    assign bus.dc_ack    = state == RESP && own_dc;
    assign bus.ic_rdata  = ic_rdata_q;
    assign bus.dc_rdata  = dc_rdata_q;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ic_cnt   <= '0;
            perf_dc_cnt   <= '0;
            perf_busy_cnt <= '0;
        end else begin
            perf_ic_cnt   <= perf_ic_cnt + {31'd0, grant_ic};
            perf_dc_cnt   <= perf_dc_cnt + {31'd0, grant_dc};
            perf_busy_cnt <= perf_busy_cnt + {31'd0, state != IDLE};
        end
    end
`else
    assign perf_ic_cnt   = '0;
    assign perf_dc_cnt   = '0;
    assign perf_busy_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration order, latency, alignment, reset abort and counters.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] perf_ic, perf_dc, perf_busy;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .perf_ic_cnt   (perf_ic),
        .perf_dc_cnt   (perf_dc),
        .perf_busy_cnt (perf_busy)
    );

    int          total = 0, bad = 0;
    int          cyc = 0, en_cnt, ic_acks, dc_acks, both_acks, en_cyc, ack_cyc;
    int          lat = 2, dc_rerun = 0;
    bit          auto_mem = 1'b1;
    logic [AW-1:0] last_addr;
    logic          last_we;
    logic [LW-1:0] last_wdata, ic_got, dc_got, rd_val;
    logic [31:0]   ord;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        en_cnt = 0; ic_acks = 0; dc_acks = 0; both_acks = 0;
        en_cyc = 0; ack_cyc = 0; ord = '0;
        last_addr = '0; last_we = 1'b0; last_wdata = '0; ic_got = '0; dc_got = '0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((bus.ic_req || bus.dc_req) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("timeout", 1, 0);
        @(negedge clk);
    endtask

    // caches: drop req when ack is seen, D-cache optionally re-raises
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (bus.ram_en) begin
            en_cnt++; en_cyc = cyc;
            last_addr = bus.ram_addr; last_we = bus.ram_write; last_wdata = bus.ram_wdata;
        end
        if (bus.ic_ack && bus.dc_ack) both_acks++;
        if (bus.ic_ack) begin
            ic_acks++; ack_cyc = cyc; ic_got = bus.ic_rdata;
            ord = {ord[29:0], 2'b01};
            bus.ic_req = 1'b0;
        end
        if (bus.dc_ack) begin
            dc_acks++; ack_cyc = cyc; dc_got = bus.dc_rdata;
            ord = {ord[29:0], 2'b10};
            if (dc_rerun > 0) dc_rerun--;
            else bus.dc_req = 1'b0;
        end
    end

    // memory: ram_valid lat cycles after ram_en
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_mem) begin
                bus.ram_valid = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.ram_valid = 1'b1;
                        bus.ram_rdata = rd_val;
                    end
                end
                if (bus.ram_en) cnt = lat;
            end
        end
    end

    initial begin
        bus.ic_req = 0; bus.ic_addr = '0; bus.dc_req = 0; bus.dc_we = 0;
        bus.dc_addr = '0; bus.dc_wdata = '0; bus.ram_rdata = '0; bus.ram_valid = 0;
        rd_val = '0;
        clear_stats();
        repeat (3) @(negedge clk);
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_ram_write", bus.ram_write, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_acks", {bus.ic_ack, bus.dc_ack}, 0);
        chk("rst_rdata", bus.ic_rdata | bus.dc_rdata, 0);
        rst = 1'b1;
        @(negedge clk);

        clear_stats(); lat = 2; rd_val = {8{32'hAAAA_AAAA}};
        bus.ic_addr = 32'h0000_1234; bus.ic_req = 1'b1;
        wait_done(50);
        chk("ic_en_cnt", en_cnt, 1);
        chk("ic_addr", last_addr, 32'h0000_1220);
        chk("ic_write", last_we, 0);
        chk("ic_acks", ic_acks, 1);
        chk("ic_rdata", ic_got, {8{32'hAAAA_AAAA}});
        chk("ic_no_dc_ack", dc_acks, 0);
        chk("ic_latency", ack_cyc - en_cyc, 3);

        clear_stats(); lat = 1; rd_val = {8{32'h5555_5555}};
        bus.dc_we = 1'b1; bus.dc_addr = 32'h40; bus.dc_wdata = {32'h0000_001E, 224'd0};
        bus.dc_req = 1'b1;
        wait_done(50);
        chk("wb_write", last_we, 1);
        chk("wb_addr", last_addr, 32'h40);
        chk("wb_wdata_top", last_wdata[255:224], 32'h1E);
        chk("wb_acks", dc_acks, 1);
        chk("wb_rdata_kept", dc_got, 0);
        chk("wb_latency", ack_cyc - en_cyc, 2);

        clear_stats(); lat = 2;
        bus.dc_we = 1'b0; bus.dc_addr = 32'h5F; bus.dc_req = 1'b1;
        wait_done(50);
        chk("dc_align", last_addr, 32'h40);
        chk("dc_rdata", dc_got, {8{32'h5555_5555}});
        chk("dc_rd_write", last_we, 0);

        clear_stats();
        bus.ic_addr = 32'h100; bus.dc_addr = 32'h200;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1;
        wait_done(80);
        chk("simul_order", ord[3:0], 4'b1001);
        chk("simul_en_cnt", en_cnt, 2);

        clear_stats(); dc_rerun = 4;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1;
        wait_done(200);
        chk("starve_order", ord[11:0], 12'hAA6);
        chk("starve_ic_acks", ic_acks, 1);
        chk("starve_dc_acks", dc_acks, 5);
        chk("starve_cnt_clr", dut.starve_cnt, 0);
        chk("never_both_ack", both_acks, 0);

        clear_stats(); auto_mem = 1'b0; rd_val = {8{32'hDEAD_BEEF}};
        bus.ic_addr = 32'h2000; bus.ic_req = 1'b1;
        for (int n = 0; n < 20 && en_cnt == 0; n++) @(negedge clk);
        chk("abort_en_seen", en_cnt, 1);
        @(negedge clk);
        rst = 1'b0; bus.ic_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.ram_valid = 1'b1; bus.ram_rdata = rd_val;
        @(negedge clk);
        bus.ram_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_acks", ic_acks + dc_acks, 0);
        chk("abort_state", dut.state, 0);
        chk("abort_ram_en", bus.ram_en, 0);
        chk("abort_en_cnt", en_cnt, 1);
        chk("abort_ic_rdata", bus.ic_rdata, 0);
        auto_mem = 1'b1; rd_val = {8{32'h3333_3333}};
        bus.dc_addr = 32'h80; bus.dc_req = 1'b1;
        wait_done(50);
        chk("after_abort_ack", dc_acks, 1);
        chk("after_abort_rdata", dc_got, {8{32'h3333_3333}});

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_stats(); lat = 2;
        for (int i = 0; i < 3; i++) begin
            bus.ic_addr = 32'h1000 + 32'(i * 32); bus.ic_req = 1'b1;
            wait_done(50);
        end
        for (int i = 0; i < 2; i++) begin
            bus.dc_addr = 32'h3000 + 32'(i * 32); bus.dc_req = 1'b1;
            wait_done(50);
        end
        chk("perf_txn_acks", ic_acks * 10 + dc_acks, 32);
`ifdef ARB_PERF_CNT_EN
        chk("perf_ic", perf_ic, 3);
        chk("perf_dc", perf_dc, 2);
        chk("perf_busy", perf_busy, 20);
`else
        chk("perf_ic", perf_ic, 0);
        chk("perf_dc", perf_dc, 0);
        chk("perf_busy", perf_busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
